ptos_tx_scheduler: RTL and testbench

//  Shares the single parallel-to-serial serializer among NREQ byte-stream requesters.

---
 rtl/ptos_tx_scheduler.sv | 164 ++++++++++++++++
 tb/tb_ptos_tx_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptos_tx_scheduler.sv
// Round-robin scheduler sharing one byte serializer among NREQ requesters; alignment COMs after reset, GAP_LEN COMs after every burst.
// Latency: req_valid to first data byte is 2 clocks (arb + transfer); backpressure: req_ready only to the owner while in BURST, a dropped valid ends the burst.
module ptos_tx_scheduler #(
    parameter int          NREQ       = 4,
    parameter int          MAX_BURST  = 8,
    parameter int          SYNC_COUNT = 4,
    parameter int          GAP_LEN    = 1,
    parameter logic [7:0]  COM        = 8'hBC
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     grant,
    output logic [7:0]          out_data,
    output logic                out_valid,
    output logic                sync_done,
    output logic                busy
);

    localparam int PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int MAX_BG  = (MAX_BURST > GAP_LEN) ? MAX_BURST : GAP_LEN;
    localparam int CNT_LIM = (SYNC_COUNT > MAX_BG) ? SYNC_COUNT : MAX_BG;
    localparam int CNT_W   = $clog2(CNT_LIM + 1);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_ARB   = 2'd1,
        ST_BURST = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   idx_q, idx_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic [7:0]         out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               sync_done_q, sync_done_d;
    logic               busy_q, busy_d;

    logic               arb_hit;
    logic [PTR_W-1:0]   arb_idx;
    logic [PTR_W-1:0]   cand;
    logic               cur_valid;
    logic               cur_last;
    logic [7:0]         cur_data;
    logic [CNT_W-1:0]   cnt_inc;
    logic [PTR_W-1:0]   ptr_nxt;
    logic               end_burst;

    assign cur_valid = req_valid[idx_q];
    assign cur_last  = req_last[idx_q];
    assign cur_data  = req_data[{idx_q, 3'b000} +: 8];
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign ptr_nxt   = (idx_q == PTR_W'(NREQ - 1)) ? '0 : idx_q + PTR_W'(1);

    // Walk offsets from the far end down so the nearest requester at or after ptr wins.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        cand    = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            cand = PTR_W'((int'(ptr_q) + j) % NREQ);
            if (req_valid[cand]) begin
                arb_hit = 1'b1;
                arb_idx = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        grant_d     = grant_q;
        out_data_d  = COM;
        out_valid_d = 1'b0;
        sync_done_d = sync_done_q;
        end_burst   = 1'b0;
        case (state_q)
            ST_SYNC: begin
                if (cnt_q == CNT_W'(SYNC_COUNT - 1)) begin
                    sync_done_d = 1'b1;
                    state_d     = ST_ARB;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_ARB: begin
                if (arb_hit) begin
                    grant_d          = '0;
                    grant_d[arb_idx] = 1'b1;
                    idx_d            = arb_idx;
                    cnt_d            = '0;
                    state_d          = ST_BURST;
                end
            end
            ST_BURST: begin
                if (cur_valid) begin
                    out_data_d  = cur_data;
                    out_valid_d = 1'b1;
                    cnt_d       = cnt_inc;
                    end_burst   = cur_last || (cnt_inc == CNT_W'(MAX_BURST));
                end else begin
                    end_burst = 1'b1;
                end
                if (end_burst) begin
                    grant_d = '0;
                    ptr_d   = ptr_nxt;
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(GAP_LEN - 1)) begin
                    state_d = ST_ARB;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = ST_SYNC;
        endcase
        busy_d = (state_d == ST_BURST) || (state_d == ST_GAP);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_SYNC;
            cnt_q       <= '0;
            ptr_q       <= '0;
            idx_q       <= '0;
            grant_q     <= '0;
            out_data_q  <= COM;
            out_valid_q <= 1'b0;
            sync_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            grant_q     <= grant_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sync_done_q <= sync_done_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = grant_q & {NREQ{state_q == ST_BURST}};
    assign grant     = grant_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign sync_done = sync_done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ptos_tx_scheduler.sv
// Scoreboarded bench for ptos_tx_scheduler: queue-fed requesters, expected bytes/grants queued at load time.
module tb_ptos_tx_scheduler;

    localparam int         NREQ = 4;
    localparam logic [7:0] COM  = 8'hBC;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [8*NREQ-1:0]   req_data;
    logic [NREQ-1:0]     req_last;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     grant;
    logic [7:0]          out_data;
    logic                out_valid;
    logic                sync_done;
    logic                busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [8:0]      src [NREQ][$];
    logic [7:0]      exp_d [$];
    logic [NREQ-1:0] exp_g [$];
    logic [NREQ-1:0] prev_g = '0;
    bit              force_all = 1'b1;

    always #5 clk = ~clk;

    ptos_tx_scheduler #(
        .NREQ(NREQ), .MAX_BURST(8), .SYNC_COUNT(4), .GAP_LEN(1), .COM(COM)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .grant(grant),
        .out_data(out_data), .out_valid(out_valid),
        .sync_done(sync_done), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Requester model: pops a byte on each accepted handshake, presents the next one at negedge.
    initial begin
        req_valid = '1;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(posedge clk);
            if (!force_all)
                for (int i = 0; i < NREQ; i++)
                    if (req_valid[i] && req_ready[i] && src[i].size() > 0)
                        void'(src[i].pop_front());
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (force_all) begin
                    req_valid[i] = 1'b1;
                end else if (src[i].size() > 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = src[i][0][7:0];
                    req_last[i]        = src[i][0][8];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'hFF;
                    req_last[i]        = 1'b0;
                end
            end
        end
    end

    // Monitor: every data byte and every new grant is checked against the queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            check("ready_vs_grant", req_ready, grant);
            if (out_valid) begin
                if (exp_d.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_byte: got %02h, expected none at %0t", out_data, $time);
                end else begin
                    check("out_byte", out_data, exp_d.pop_front());
                end
            end else begin
                check("idle_com", out_data, COM);
            end
            if (grant != prev_g && grant != '0) begin
                if (exp_g.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_grant: got %b, expected none at %0t", grant, $time);
                end else begin
                    check("grant_order", grant, exp_g.pop_front());
                end
            end
            prev_g = grant;
        end
    end

    task automatic wait_byte(input logic [7:0] b);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            #1;
            if (out_valid && out_data == b) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL wait_byte: got no %02h, expected it within 200 clocks", b);
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            #1;
            done = exp_d.size() == 0 && exp_g.size() == 0 && !busy && grant == '0 &&
                   src[0].size() == 0 && src[1].size() == 0 &&
                   src[2].size() == 0 && src[3].size() == 0;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL drain: got %0d bytes %0d grants pending, expected 0", exp_d.size(), exp_g.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic sync_phase();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                @(posedge clk);
                #1 force_all = 1'b0;
            end
            @(negedge clk);
            #1;
            check("sync_valid", out_valid, 1'b0);
            check("sync_grant", grant, '0);
            check("sync_done", sync_done, (i == 3));
        end
    endtask

    initial begin
        // T1: reset with every requester asserting valid
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("rst_valid", out_valid, 1'b0);
            check("rst_data", out_data, COM);
            check("rst_grant", grant, '0);
            check("rst_ready", req_ready, '0);
            check("rst_sync_done", sync_done, 1'b0);
            check("rst_busy", busy, 1'b0);
        end
        reset = 1'b1;
        sync_phase();
        @(negedge clk);
        #1;
        check("arb_idle_busy", busy, 1'b0);

        // T2: single 4-byte packet from req0, 2-clock first-byte latency
        @(posedge clk);
        #2;
        src[0].push_back({1'b0, 8'hAA});
        src[0].push_back({1'b0, 8'hEE});
        src[0].push_back({1'b0, 8'hEE});
        src[0].push_back({1'b1, 8'hCC});
        exp_g.push_back(4'b0001);
        exp_d.push_back(8'hAA); exp_d.push_back(8'hEE);
        exp_d.push_back(8'hEE); exp_d.push_back(8'hCC);
        @(negedge clk);
        #1 check("t2_no_grant_yet", grant, '0);
        @(negedge clk);
        #1 check("t2_arb_grant", grant, 4'b0001);
        check("t2_arb_com", out_valid, 1'b0);
        @(negedge clk);
        #1 check("t2_first_byte", {out_valid, out_data}, {1'b1, 8'hAA});
        wait_byte(8'hCC);
        check("t2_last_busy", busy, 1'b1);
        check("t2_last_grant", grant, '0);
        @(negedge clk);
        #1 check("t2_gap_com", out_valid, 1'b0);
        check("t2_gap_over", busy, 1'b0);
        drain();

        // T3: 10 bytes from req2 without last; burst capped at 8
        @(posedge clk);
        #2;
        for (int b = 1; b <= 10; b++) begin
            src[2].push_back({1'b0, 8'(b)});
            exp_d.push_back(8'(b));
        end
        exp_g.push_back(4'b0100);
        exp_g.push_back(4'b0100);
        wait_byte(8'h08);
        check("t3_cap_grant", grant, '0);
        check("t3_cap_busy", busy, 1'b1);
        drain();

        // Move ptr to 0 with one byte from req3
        @(posedge clk);
        #2;
        src[3].push_back({1'b1, 8'h3F});
        exp_g.push_back(4'b1000);
        exp_d.push_back(8'h3F);
        drain();

        // T4: all four valid with single-byte packets; req0 has two
        @(posedge clk);
        #2;
        src[0].push_back({1'b1, 8'h40});
        src[0].push_back({1'b1, 8'h41});
        src[1].push_back({1'b1, 8'h50});
        src[2].push_back({1'b1, 8'h60});
        src[3].push_back({1'b1, 8'h70});
        exp_g.push_back(4'b0001); exp_g.push_back(4'b0010);
        exp_g.push_back(4'b0100); exp_g.push_back(4'b1000);
        exp_g.push_back(4'b0001);
        exp_d.push_back(8'h40); exp_d.push_back(8'h50);
        exp_d.push_back(8'h60); exp_d.push_back(8'h70);
        exp_d.push_back(8'h41);
        drain();

        // T5: req1 drops valid after two bytes, req2 waiting
        @(posedge clk);
        #2;
        src[1].push_back({1'b0, 8'h51});
        src[1].push_back({1'b0, 8'h52});
        src[2].push_back({1'b0, 8'h61});
        src[2].push_back({1'b1, 8'h62});
        exp_g.push_back(4'b0010);
        exp_g.push_back(4'b0100);
        exp_d.push_back(8'h51); exp_d.push_back(8'h52);
        exp_d.push_back(8'h61); exp_d.push_back(8'h62);
        wait_byte(8'h52);
        @(negedge clk);
        #1 check("t5_drop_com", {out_valid, out_data}, {1'b0, COM});
        check("t5_drop_grant", grant, '0);
        check("t5_drop_busy", busy, 1'b1);
        drain();

        // T6: reset during req3's third byte, then resync and restart from ptr 0
        @(posedge clk);
        #2;
        for (int b = 1; b <= 6; b++) src[3].push_back({(b == 6), 8'h80 + 8'(b)});
        exp_g.push_back(4'b1000);
        exp_d.push_back(8'h81);
        exp_d.push_back(8'h82);
        wait_byte(8'h82);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("t6_rst_valid", out_valid, 1'b0);
        check("t6_rst_data", out_data, COM);
        check("t6_rst_grant", grant, '0);
        check("t6_rst_ready", req_ready, '0);
        check("t6_rst_sync_done", sync_done, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        @(posedge clk);
        #2;
        for (int i = 0; i < NREQ; i++) src[i].delete();
        src[0].push_back({1'b1, 8'h90});
        src[3].push_back({1'b1, 8'h93});
        exp_g.push_back(4'b0001);
        exp_g.push_back(4'b1000);
        exp_d.push_back(8'h90);
        exp_d.push_back(8'h93);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("t6_sync_grant", grant, '0);
            check("t6_sync_done", sync_done, (i == 3));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
